// File: rtl/hazard_stall_unit_if.sv
// Hazard-unit bus: hazard-detection inputs from ID/EX/MEM and the resulting
// pipeline enables, flushes and performance counters.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       id_ex_rd;
    logic             id_ex_mem_read;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_en;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_ex_rd, id_ex_mem_read,
               branch_taken, dmem_req, dmem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_en,
               stall_count, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_ex_rd, id_ex_mem_read,
               branch_taken, dmem_req, dmem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_en,
               stall_count, flush_count
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// data-memory wait freezes, with saturating stall/flush event counters.
module hazard_stall_unit #(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_stall_unit_if.slave  bus
);
    typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

    localparam logic [1:0]       BUBBLE_INIT = 2'(LOAD_USE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t           state_reg, state_next;
    logic [1:0]       bubble_reg, bubble_next;
    logic [CNT_W-1:0] stall_count_reg, flush_count_reg;

    logic load_use, mem_stall, flush_event;
    logic pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_en;

    assign load_use = bus.id_ex_mem_read && (bus.id_ex_rd != 5'd0) &&
                      ((bus.id_use_rs1 && (bus.id_ex_rd == bus.id_rs1)) ||
                       (bus.id_use_rs2 && (bus.id_ex_rd == bus.id_rs2)));
    assign mem_stall = bus.dmem_req && !bus.dmem_ready;

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_en     = 1'b1;
        flush_event = 1'b0;
        state_next  = state_reg;
        bubble_next = bubble_reg;

        case (state_reg)
            RUN: begin
                if (mem_stall) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_en     = 1'b0;
                    state_next  = MEM_WAIT;
                end else if (bus.branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    flush_event = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    if (LOAD_USE_CYCLES > 1) begin
                        bubble_next = BUBBLE_INIT;
                        state_next  = LOAD_STALL;
                    end
                end
            end
            LOAD_STALL: begin
                if (mem_stall) begin
                    // Bubble count is frozen; the hazard is re-detected once back in RUN.
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_en     = 1'b0;
                    state_next  = MEM_WAIT;
                end else if (bus.branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    flush_event = 1'b1;
                    bubble_next = 2'd0;
                    state_next  = RUN;
                end else begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    bubble_next = bubble_reg - 2'd1;
                    if (bubble_reg <= 2'd1) begin
                        state_next = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                pipe_en     = bus.dmem_ready;
                if (bus.dmem_ready) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next  = RUN;
                bubble_next = 2'd0;
            end
        endcase

        if (rst) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            pipe_en     = 1'b0;
            flush_event = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            bubble_reg      <= 2'd0;
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            state_reg  <= state_next;
            bubble_reg <= bubble_next;
            if (!pc_write && (stall_count_reg != CNT_MAX)) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end
            if (flush_event && (flush_count_reg != CNT_MAX)) begin
                flush_count_reg <= flush_count_reg + 1'b1;
            end
        end
    end

    assign bus.pc_write    = pc_write;
    assign bus.if_id_write = if_id_write;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.pipe_en     = pipe_en;
    assign bus.stall_count = stall_count_reg;
    assign bus.flush_count = flush_count_reg;
endmodule
